// File: rtl/sdf_issue_arbiter.sv
// sdf_issue_arbiter: round-robin issue of engine queries into one fixed-latency sdf pipeline,
// with a tag shift register routing each returning distance back to its engine.
module sdf_issue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SDF_LATENCY = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [27*NUM_REQ-1:0]          req_x,
  input  logic [27*NUM_REQ-1:0]          req_y,
  input  logic [27*NUM_REQ-1:0]          req_z,
  output logic [26:0]                    sdf_point_x,
  output logic [26:0]                    sdf_point_y,
  output logic [26:0]                    sdf_point_z,
  input  logic [26:0]                    sdf_distance,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [26:0]                    resp_distance,
  output logic [$clog2(NUM_REQ+1)-1:0]   inflight,
  output logic                           idle
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_REQ+1);
  // One extra stage covers the point register, so the last tag lines up with the sampled distance.
  localparam int NT = SDF_LATENCY + 1;

  logic [NUM_REQ-1:0]       out_q, out_d, elig, ret_oh;
  logic [IW-1:0]            rr_q, rr_d, gidx;
  logic [IW:0]              idx;
  logic                     acc, ret;
  logic [NT-1:0]            tv_q;
  logic [NT-1:0][IW-1:0]    tid_q;
  logic [CW-1:0]            inf_q, inf_d;

  always_comb begin
    elig      = req_valid & ~out_q;
    req_ready = '0;
    gidx      = '0;
    acc       = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (!acc && elig[idx[IW-1:0]]) begin
        req_ready[idx[IW-1:0]] = 1'b1;
        gidx                   = idx[IW-1:0];
        acc                    = 1'b1;
      end
    end
  end

  assign ret    = tv_q[NT-1];
  assign ret_oh = ret ? (NUM_REQ'(1) << tid_q[NT-1]) : '0;
  assign out_d  = (out_q & ~ret_oh) | req_ready;
  assign rr_d   = !acc ? rr_q : (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
  assign inf_d  = inf_q + CW'(acc) - CW'(ret);
  assign inflight = inf_q;
  assign idle     = (inf_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= '0;
      rr_q          <= '0;
      tv_q          <= '0;
      tid_q         <= '0;
      inf_q         <= '0;
      sdf_point_x   <= '0;
      sdf_point_y   <= '0;
      sdf_point_z   <= '0;
      resp_valid    <= '0;
      resp_distance <= '0;
    end else begin
      out_q      <= out_d;
      rr_q       <= rr_d;
      tv_q       <= {tv_q[NT-2:0], acc};
      tid_q      <= {tid_q[NT-2:0], gidx};
      inf_q      <= inf_d;
      resp_valid <= ret_oh;
      if (acc) begin
        sdf_point_x <= req_x[27*gidx +: 27];
        sdf_point_y <= req_y[27*gidx +: 27];
        sdf_point_z <= req_z[27*gidx +: 27];
      end
      if (ret) resp_distance <= sdf_distance;
    end
  end
endmodule

// File: tb/tb_sdf_issue_arbiter.sv
// tb_sdf_issue_arbiter: random and directed stimulus against a queue-based model of issue/return;
// sdf is modelled as a delay line of sdf_point_x.
module tb_sdf_issue_arbiter;
  localparam int N = 4;
  localparam int L = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, resp_valid;
  logic [27*N-1:0] req_x, req_y, req_z;
  logic [26:0] sdf_point_x, sdf_point_y, sdf_point_z, sdf_distance, resp_distance;
  logic [2:0] inflight;
  logic idle;

  always #5 clk = ~clk;

  sdf_issue_arbiter #(.NUM_REQ(N), .SDF_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .sdf_point_x(sdf_point_x), .sdf_point_y(sdf_point_y), .sdf_point_z(sdf_point_z),
    .sdf_distance(sdf_distance), .resp_valid(resp_valid), .resp_distance(resp_distance),
    .inflight(inflight), .idle(idle)
  );

  logic [26:0] line [L];
  always_ff @(posedge clk) begin
    line[0] <= sdf_point_x;
    for (int i = 1; i < L; i++) line[i] <= line[i-1];
  end

  typedef struct {int due; int id; logic [26:0] d;} item_t;
  item_t pend[$];
  bit m_out [N];
  int m_rr, n_edge, checks, passed;
  logic [N-1:0] m_rv;
  logic [26:0] m_rd, m_px, m_py, m_pz;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int grant(logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (v[i] && !m_out[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < N; i++) m_out[i] = 0;
    m_rr = 0; m_rv = '0; m_rd = '0; m_px = '0; m_py = '0; m_pz = '0;
  endtask

  task automatic step(logic [N-1:0] v, bit fx = 0);
    int g;
    bit due;
    @(negedge clk);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_x[27*i +: 27] = 27'($urandom);
      req_y[27*i +: 27] = 27'($urandom);
      req_z[27*i +: 27] = 27'($urandom);
    end
    if (fx) req_x[27*2 +: 27] = 27'h1fc0000;
    due = 0;
    foreach (pend[j]) if (pend[j].due == n_edge + 1) due = 1;
    sdf_distance = due ? line[L-1] : 27'($urandom);
    #1;
    g = grant(v);
    chk("req_ready", 32'(req_ready), g < 0 ? 0 : 32'(1) << g);
    chk("resp_valid", 32'(resp_valid), 32'(m_rv));
    chk("resp_distance", 32'(resp_distance), 32'(m_rd));
    chk("sdf_point_x", 32'(sdf_point_x), 32'(m_px));
    chk("sdf_point_y", 32'(sdf_point_y), 32'(m_py));
    chk("sdf_point_z", 32'(sdf_point_z), 32'(m_pz));
    chk("inflight", 32'(inflight), 32'(pend.size()));
    chk("idle", 32'(idle), 32'(pend.size() == 0));
    @(posedge clk);
    n_edge++;
    m_rv = '0;
    for (int j = 0; j < pend.size(); j++)
      if (pend[j].due == n_edge) begin
        m_rv[pend[j].id] = 1'b1;
        m_rd = pend[j].d;
        m_out[pend[j].id] = 0;
        pend.delete(j);
        break;
      end
    if (g >= 0) begin
      m_out[g] = 1;
      m_rr = (g + 1) % N;
      m_px = req_x[27*g +: 27];
      m_py = req_y[27*g +: 27];
      m_pz = req_z[27*g +: 27];
      pend.push_back('{n_edge + L + 1, g, req_x[27*g +: 27]});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    model_clear();
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_distance", 32'(resp_distance), 0);
    chk("rst_point_x", 32'(sdf_point_x), 0);
    chk("rst_point_z", 32'(sdf_point_z), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req_valid = '0; req_x = '0; req_y = '0; req_z = '0; sdf_distance = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 1);
    repeat (16) step(4'b0000);
    repeat (60) step(4'b1111);
    do_reset();
    step(4'b0010);
    repeat (12) step(4'b1010);
    repeat (16) step(4'b0000);
    step(4'b0001);
    repeat (12) step(4'b0000);
    step(4'b0010);
    repeat (16) step(4'b0000);
    repeat (400) step(N'($urandom));
    do_reset();
    repeat (3) step(4'b0111);
    do_reset();
    repeat (2*L) step(4'b0000);
    repeat (40) step(N'($urandom));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
